// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/freeze controller for the 5-stage MIPS pipeline.
// Generates pipeline-register enables from operand hazards (Tuse/Tnew),
// mult/div occupancy and data-memory wait states. Also provides a
// memory-timeout watchdog and saturating stall/freeze counters.
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  input  logic [1:0]  D_tuse_rs,
  input  logic [1:0]  D_tuse_rt,
  input  logic        D_is_md,
  input  logic [4:0]  E_wa,
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_wa,
  input  logic [1:0]  M_tnew,
  input  logic        E_md_start,
  input  logic        E_md_op,
  input  logic        M_mem_req,
  input  logic        M_mem_ready,
  output logic        PC_en,
  output logic        F2D_en,
  output logic        D2E_en,
  output logic        D2E_clr,
  output logic        E2M_en,
  output logic        M2W_en,
  output logic        md_busy,
  output logic        md_done,
  output logic        mem_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] freeze_cycles
);

  localparam logic [7:0]  LP_MULT_LD = 8'(MULT_CYCLES);
  localparam logic [7:0]  LP_DIV_LD  = 8'(DIV_CYCLES);
  localparam logic [15:0] LP_TO_LAST = 16'(MEM_TIMEOUT - 1);

  logic [7:0]  r_md_cnt;
  logic        r_md_done;
  logic [15:0] r_frz_cnt;
  logic        r_mem_err;
  logic [31:0] r_stall_cycles;
  logic [31:0] r_freeze_cycles;

  logic w_freeze;
  logic w_cnt_nz;
  logic w_stall_rs;
  logic w_stall_rt;
  logic w_stall_md;
  logic w_stall;
  logic w_md_load;

  assign w_freeze = M_mem_req & ~M_mem_ready;
  assign w_cnt_nz = (r_md_cnt != 8'd0);

  // Operand hazards: a producer still further from forwardable than the
  // consumer can tolerate. Tuse = 3 exceeds every legal Tnew, so it never stalls.
  always_comb begin
    w_stall_rs = 1'b0;
    w_stall_rt = 1'b0;
    if (D_rs_addr != 5'd0) begin
      w_stall_rs = ((E_wa == D_rs_addr) && (E_tnew > D_tuse_rs)) ||
                   ((M_wa == D_rs_addr) && (M_tnew > D_tuse_rs));
    end
    if (D_rt_addr != 5'd0) begin
      w_stall_rt = ((E_wa == D_rt_addr) && (E_tnew > D_tuse_rt)) ||
                   ((M_wa == D_rt_addr) && (M_tnew > D_tuse_rt));
    end
  end

  assign w_stall_md = D_is_md & (w_cnt_nz | E_md_start);
  assign w_stall    = w_stall_rs | w_stall_rt | w_stall_md;

  // A start issued during a freeze waits; the frozen E stage keeps presenting it.
  assign w_md_load  = E_md_start & ~w_freeze & ~w_cnt_nz;

  // Enable decode: freeze beats stall; reset forces a free-running pipeline.
  always_comb begin
    PC_en   = 1'b1;
    F2D_en  = 1'b1;
    D2E_en  = 1'b1;
    D2E_clr = 1'b0;
    E2M_en  = 1'b1;
    M2W_en  = 1'b1;
    if (!reset) begin
      if (w_freeze) begin
        PC_en  = 1'b0;
        F2D_en = 1'b0;
        D2E_en = 1'b0;
        E2M_en = 1'b0;
        M2W_en = 1'b0;
      end else if (w_stall) begin
        PC_en   = 1'b0;
        F2D_en  = 1'b0;
        D2E_clr = 1'b1;
      end
    end
  end

  // Mult/div busy counter; keeps counting through a freeze since the unit
  // runs independently of the pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_cnt  <= 8'd0;
      r_md_done <= 1'b0;
    end else begin
      r_md_done <= (r_md_cnt == 8'd1);
      if (w_md_load) begin
        r_md_cnt <= E_md_op ? LP_DIV_LD : LP_MULT_LD;
      end else if (w_cnt_nz) begin
        r_md_cnt <= r_md_cnt - 8'd1;
      end
    end
  end

  // Memory watchdog: counts consecutive freeze cycles, sets a sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frz_cnt <= 16'd0;
      r_mem_err <= 1'b0;
    end else if (w_freeze) begin
      if (r_frz_cnt == LP_TO_LAST) begin
        r_mem_err <= 1'b1;
      end
      if (r_frz_cnt != 16'hFFFF) begin
        r_frz_cnt <= r_frz_cnt + 16'd1;
      end
    end else begin
      r_frz_cnt <= 16'd0;
    end
  end

  // Saturating performance counters; a stall hidden under a freeze is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles  <= 32'd0;
      r_freeze_cycles <= 32'd0;
    end else begin
      if (w_stall && !w_freeze && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_freeze && (r_freeze_cycles != 32'hFFFF_FFFF)) begin
        r_freeze_cycles <= r_freeze_cycles + 32'd1;
      end
    end
  end

  assign md_busy       = w_cnt_nz & ~reset;
  assign md_done       = r_md_done;
  assign mem_err       = r_mem_err;
  assign stall_cycles  = r_stall_cycles;
  assign freeze_cycles = r_freeze_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs_addr, D_rt_addr, E_wa, M_wa;
  logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic        D_is_md, E_md_start, E_md_op, M_mem_req, M_mem_ready;
  logic        PC_en, F2D_en, D2E_en, D2E_clr, E2M_en, M2W_en;
  logic        md_busy, md_done, mem_err;
  logic [31:0] stall_cycles, freeze_cycles;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .MEM_TIMEOUT(4)) u_dut (
    .clk(clk), .reset(reset),
    .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
    .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_is_md(D_is_md),
    .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_op(E_md_op),
    .M_mem_req(M_mem_req), .M_mem_ready(M_mem_ready),
    .PC_en(PC_en), .F2D_en(F2D_en), .D2E_en(D2E_en), .D2E_clr(D2E_clr),
    .E2M_en(E2M_en), .M2W_en(M2W_en),
    .md_busy(md_busy), .md_done(md_done), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .freeze_cycles(freeze_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs are then changed away from the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    D_rs_addr = 0; D_rt_addr = 0; D_tuse_rs = 3; D_tuse_rt = 3; D_is_md = 0;
    E_wa = 0; E_tnew = 0; M_wa = 0; M_tnew = 0;
    E_md_start = 0; E_md_op = 0; M_mem_req = 0; M_mem_ready = 0;
  endtask

  // {PC,F2D,D2E,D2E_clr,E2M,M2W}
  function automatic logic [5:0] ens();
    return {PC_en, F2D_en, D2E_en, D2E_clr, E2M_en, M2W_en};
  endfunction

  int busy_n;

  initial begin
    idle();
    reset = 1'b1;
    cyc(); cyc();
    chk("rst_en", 32'(ens()), 32'b111011);
    chk("rst_busy", 32'(md_busy), 0);
    reset = 1'b0;
    #1;
    chk("rst_cnt", stall_cycles | freeze_cycles, 0);
    chk("rst_err", 32'(mem_err), 0);

    // load-use on rs
    E_wa = 5; E_tnew = 2; D_rs_addr = 5; D_tuse_rs = 1; #1;
    chk("lu_stall", 32'(ens()), 32'b001111);
    cyc();
    E_wa = 0; E_tnew = 0; M_wa = 5; M_tnew = 1; #1;
    chk("lu_m_nostall", 32'(ens()), 32'b111011);
    chk("lu_stall_cnt", stall_cycles, 1);
    cyc();
    D_tuse_rs = 0; #1;
    chk("m_tnew1_tuse0", 32'(ens()), 32'b001111);
    cyc();
    idle(); E_wa = 0; D_rs_addr = 0; E_tnew = 2; D_tuse_rs = 0; #1;
    chk("zero_reg", 32'(PC_en), 1);
    chk("zero_stall_cnt", stall_cycles, 2);
    cyc();
    idle(); D_rt_addr = 7; E_wa = 7; E_tnew = 2; D_tuse_rt = 1; #1;
    chk("rt_stall", 32'(D2E_clr), 1);
    cyc();
    D_tuse_rt = 3; #1;
    chk("tuse3", 32'(ens()), 32'b111011);
    chk("rt_stall_cnt", stall_cycles, 3);

    // mult followed by mfhi
    cyc();
    idle(); E_md_start = 1; E_md_op = 0; D_is_md = 1; #1;
    chk("mult_start_stall", 32'(ens()), 32'b001111);
    chk("mult_busy0", 32'(md_busy), 0);
    cyc();
    E_md_start = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("mult_busy", 32'(md_busy), 1);
      chk("mult_md_stall", 32'(PC_en), 0);
      chk("mult_nodone", 32'(md_done), 0);
      cyc();
    end
    #1;
    chk("mult_busy_end", 32'(md_busy), 0);
    chk("mult_done", 32'(md_done), 1);
    chk("mult_stall_clr", 32'(PC_en), 1);
    chk("mult_stall_cnt", stall_cycles, 9);
    cyc();
    idle(); #1;
    chk("mult_done_1cyc", 32'(md_done), 0);

    // div overlapped with a 3-cycle freeze
    E_md_start = 1; E_md_op = 1; #1;
    cyc();
    idle();
    busy_n = 0;
    for (int i = 0; i < 30; i++) begin
      if (i < 3) begin
        M_mem_req = 1; M_mem_ready = 0; D_is_md = 1;
      end else begin
        idle();
      end
      #1;
      if (i < 3) chk("frz_en", 32'(ens()), 32'b000000);
      if (!md_busy) break;
      busy_n++;
      cyc();
    end
    chk("div_busy_len", busy_n, 10);
    chk("div_frz_cnt", freeze_cycles, 3);
    chk("div_stall_cnt", stall_cycles, 9);

    // start deferred by freeze
    cyc();
    idle(); E_md_start = 1; E_md_op = 0; M_mem_req = 1; #1;
    cyc();
    #1;
    chk("defer_busy", 32'(md_busy), 0);
    M_mem_req = 0; #1;
    cyc();
    idle(); #1;
    chk("defer_load", 32'(md_busy), 1);
    for (int i = 0; i < 10 && md_busy; i++) cyc();
    chk("defer_drain", 32'(md_busy), 0);
    chk("defer_frz_cnt", freeze_cycles, 4);

    // memory timeout (MEM_TIMEOUT = 4)
    for (int i = 1; i <= 6; i++) begin
      M_mem_req = 1; M_mem_ready = 0;
      cyc();
      chk($sformatf("to_err_%0d", i), 32'(mem_err), (i >= 4) ? 32'd1 : 32'd0);
    end
    idle();
    cyc();
    chk("to_sticky", 32'(mem_err), 1);
    chk("to_frz_cnt", freeze_cycles, 10);
    chk("to_en_free", 32'(ens()), 32'b111011);

    // reset mid-mult abandons the count without a done pulse
    E_md_start = 1; E_md_op = 0; #1;
    cyc();
    idle(); cyc();
    reset = 1'b1; #1;
    chk("rstmid_busy", 32'(md_busy), 0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rstmid_nodone", 32'(md_done | md_busy), 0);
      cyc();
    end
    chk("rstmid_err", 32'(mem_err), 0);
    chk("rstmid_cnt", stall_cycles | freeze_cycles, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/freeze controller for the 5-stage MIPS pipeline. It drives the enable and clear strobes of PC, F2D, D2E, E2M and M2W from three sources:
- register-operand hazards between D and the E/M stages, using Tuse/Tnew;
- occupancy of the multi-cycle mult/div unit, tracked by an internal busy counter;
- data-memory wait states, which freeze the whole pipeline.
It also keeps a memory-timeout watchdog and stall/freeze performance counters.

Parameters:
MULT_CYCLES, 5, busy cycles loaded on a mult start (1..255)
DIV_CYCLES, 10, busy cycles loaded on a div start (1..255)
MEM_TIMEOUT, 64, consecutive freeze cycles before mem_err sets (1..65535)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
D_rs_addr  in  5  rs index read by instr in D
D_rt_addr  in  5  rt index read by instr in D
D_tuse_rs  in  2  cycles until D instr needs rs (3 = unused)
D_tuse_rt  in  2  cycles until D instr needs rt (3 = unused)
D_is_md  in  1  D instr uses mult/div unit (mult/div/mfhi/mflo/mthi/mtlo)
E_wa  in  5  dest reg of instr in E (0 = none)
E_tnew  in  2  cycles until E result is forwardable (0..2)
M_wa  in  5  dest reg of instr in M (0 = none)
M_tnew  in  2  cycles until M result is forwardable (0..1)
E_md_start  in  1  instr in E is mult/multu/div/divu
E_md_op  in  1  0 = mult class, 1 = div class
M_mem_req  in  1  instr in M accesses data memory
M_mem_ready  in  1  data memory completes access this cycle
PC_en  out  1  PC update enable
F2D_en  out  1  F2D register enable
D2E_en  out  1  D2E register enable
D2E_clr  out  1  load bubble into D2E
E2M_en  out  1  E2M register enable
M2W_en  out  1  M2W register enable
md_busy  out  1  mult/div unit busy
md_done  out  1  one-cycle pulse when the busy count reaches 0
mem_err  out  1  sticky memory-timeout flag
stall_cycles  out  32  count of hazard-stall cycles, saturating
freeze_cycles  out  32  count of freeze cycles, saturating

Behaviour:
- Reset (synchronous), applied at the clock edge:
  - md_cnt = 0, frz_cnt = 0; mem_err, md_done, stall_cycles, freeze_cycles all = 0.
  - While reset is high, force all *_en = 1, D2E_clr = 0, md_busy = 0.
  - A reset mid-operation abandons any in-flight mult/div count; md_done does not pulse.
- Freeze condition: freeze = M_mem_req & ~M_mem_ready.
- Hazard stall per operand, for X in {rs, rt}. A stall is raised when D_X_addr != 0 and either:
  - E_wa == D_X_addr and E_tnew > D_tuse_X; or
  - M_wa == D_X_addr and M_tnew > D_tuse_X.
  - Tuse = 3 never stalls.
- MD stall: D_is_md & (md_busy | E_md_start).
- stall = rs stall | rt stall | MD stall.
- Enable decode (combinational, same cycle):
  - freeze (priority over stall): PC_en = F2D_en = D2E_en = E2M_en = M2W_en = 0, D2E_clr = 0.
  - else stall: PC_en = F2D_en = 0; D2E_en = 1, D2E_clr = 1; E2M_en = M2W_en = 1.
  - else: all enables 1, D2E_clr = 0.
- Mult/div counter md_cnt (8 bits), with md_busy = (md_cnt != 0):
  - If E_md_start & ~freeze & ~md_busy: load MULT_CYCLES or DIV_CYCLES according to E_md_op. md_busy rises the next cycle and stays high for exactly N cycles.
  - If E_md_start arrives while busy: ignored.
  - While freeze is high: the start load is deferred until freeze drops.
  - Else if md_cnt != 0: decrement every cycle, freeze or not.
  - md_done is registered: high for one cycle, in the cycle after md_cnt transitions 1 -> 0.
- Watchdog:
  - frz_cnt increments each freeze cycle and clears when freeze is low.
  - When frz_cnt reaches MEM_TIMEOUT - 1 while freeze is still high, mem_err sets on that edge and stays set until reset.
  - The pipeline remains frozen regardless of mem_err.
- Counters:
  - stall_cycles increments on each cycle with stall & ~freeze.
  - freeze_cycles increments on each freeze cycle.
  - Both hold at 0xFFFFFFFF.

Test Plan:
- Reset for 2 cycles -> all *_en = 1, D2E_clr = 0, md_busy = 0, counters 0, mem_err = 0.
- Load-use: E_wa = 5, E_tnew = 2, D_rs_addr = 5, D_tuse_rs = 1 -> PC_en = F2D_en = 0, D2E_clr = 1 for that cycle. The next cycle presents M_wa = 5, M_tnew = 1 -> no stall; stall_cycles = 1.
- Zero register: E_wa = 0, D_rs_addr = 0, E_tnew = 2, D_tuse_rs = 0 -> no stall.
- Mult then mfhi: E_md_start = 1, E_md_op = 0, D_is_md = 1 -> stall that cycle; md_busy high for 5 cycles, with D_is_md stalling throughout; md_done pulses once; the stall clears the cycle md_busy falls.
- Div with freeze overlap: start div, then hold M_mem_req = 1, M_mem_ready = 0 for 3 cycles -> all enables 0 (stall ignored); md_cnt keeps decrementing, so md_busy lasts exactly 10 cycles; freeze_cycles = 3.
- Timeout: MEM_TIMEOUT = 4, freeze held 6 cycles -> mem_err set at the 4th edge, stays set after freeze ends, clears only on reset.
